ret_addr_stack: RTL and testbench

Parametrised hardware return-address stack for the core's CALL/RETURN and interrupt-entry path, replacing the fixed 4-entry, 11-bit, reset-less shift stack. It is generalised in address width and depth. It adds an asynchronous reset, occupancy and full/empty status, a selectable overflow policy (circular or saturating), sticky overflow/underflow flags, a replace-top operation and a synchronous flush. The fetch unit pushes the return PC on CALL/interrupt, pops on RETURN/RETLW/RETFIE, and reads the top-of-stack combinationally.

---
 rtl/ret_addr_stack_pkg.sv | 12 +
 rtl/ret_addr_stack.sv | 141 ++++++++++++++
 tb/tb_ret_addr_stack.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ret_addr_stack_pkg.sv
// Shared definitions for the return-address stack: operation encodings used by
// the stack and the core decoder.
package ret_addr_stack_pkg;

    typedef enum logic [1:0] {
        STK_NOP = 2'b00,
        STK_PSH = 2'b01,
        STK_POP = 2'b10,
        STK_RPL = 2'b11
    } stk_op_e;

endpackage : ret_addr_stack_pkg

// File: rtl/ret_addr_stack.sv
// Parametrised return-address stack: ring storage with explicit pointer wrap,
// occupancy status, circular or saturating overflow policy and sticky flags.
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int AW    = 11,
    parameter int DEPTH = 8,
    parameter int WRAP  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   ctl,
    input  logic [AW-1:0]                din,
    input  logic                         flush,
    input  logic                         clr_flags,
    output logic [AW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         ovf,
    output logic                         unf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] C_PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    // Pointer moves wrap explicitly so any depth, not only powers of two, works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == C_PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == {PW{1'b0}}) ? C_PTR_LAST : p - PW'(1);
    endfunction

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_tp;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_unf;

    logic [PW-1:0] w_tp_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [PW-1:0] w_wr_ptr;
    logic          w_wr_en;
    logic          w_set_ovf;
    logic          w_set_unf;
    logic          w_empty;
    logic          w_full;

    assign w_empty = (r_cnt == {CW{1'b0}});
    assign w_full  = (r_cnt == C_CNT_FULL);

    // Next pointer/count, write request and flag events for this cycle.
    always_comb begin
        w_tp_nxt  = r_tp;
        w_cnt_nxt = r_cnt;
        w_wr_ptr  = r_tp;
        w_wr_en   = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (flush) begin
            w_tp_nxt  = {PW{1'b0}};
            w_cnt_nxt = {CW{1'b0}};
        end else begin
            case (stk_op_e'(ctl))
                STK_PSH: begin
                    if (!w_full) begin
                        w_tp_nxt  = ptr_inc(r_tp);
                        w_wr_ptr  = ptr_inc(r_tp);
                        w_wr_en   = 1'b1;
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end else if (WRAP != 0) begin
                        w_tp_nxt  = ptr_inc(r_tp);
                        w_wr_ptr  = ptr_inc(r_tp);
                        w_wr_en   = 1'b1;
                        w_set_ovf = 1'b1;
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                end
                STK_POP: begin
                    if (!w_empty) begin
                        w_tp_nxt  = ptr_dec(r_tp);
                        w_cnt_nxt = r_cnt - C_CNT_ONE;
                    end else begin
                        w_set_unf = 1'b1;
                    end
                end
                STK_RPL: begin
                    // Replace on an empty stack degrades to a push of din.
                    if (!w_empty) begin
                        w_wr_en   = 1'b1;
                    end else begin
                        w_tp_nxt  = ptr_inc(r_tp);
                        w_wr_ptr  = ptr_inc(r_tp);
                        w_wr_en   = 1'b1;
                        w_cnt_nxt = C_CNT_ONE;
                        w_set_unf = 1'b1;
                    end
                end
                default: begin
                    w_tp_nxt = r_tp;
                end
            endcase
        end
    end

    // Pointer, occupancy and sticky flags; a flag-setting event beats clr_flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tp  <= {PW{1'b0}};
            r_cnt <= {CW{1'b0}};
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_tp  <= w_tp_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= (r_ovf & ~clr_flags) | w_set_ovf;
            r_unf <= (r_unf & ~clr_flags) | w_set_unf;
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[w_wr_ptr] <= din;
        end
    end

    assign dout  = w_empty ? {AW{1'b0}} : r_mem[r_tp];
    assign count = r_cnt;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule : ret_addr_stack

// File: tb/tb_ret_addr_stack.sv
// Directed self-checking bench: circular and saturating 8-deep stacks plus a
// 5-deep, 13-bit circular stack, with hand-computed expectations.
module tb_ret_addr_stack;
    import ret_addr_stack_pkg::*;

    logic clk;
    logic rst;

    logic [1:0]  ctl_ab;
    logic [10:0] din_ab;
    logic        flush_ab;
    logic        clr_ab;

    logic [1:0]  ctl_c;
    logic [12:0] din_c;
    logic        flush_c;
    logic        clr_c;

    logic [10:0] a_dout, b_dout;
    logic [3:0]  a_count, b_count;
    logic        a_empty, a_full, a_ovf, a_unf;
    logic        b_empty, b_full, b_ovf, b_unf;
    logic [12:0] c_dout;
    logic [2:0]  c_count;
    logic        c_empty, c_full, c_ovf, c_unf;

    int n_cmp  = 0;
    int n_fail = 0;

    ret_addr_stack #(.AW(11), .DEPTH(8), .WRAP(1)) u_a (
        .clk(clk), .rst(rst), .ctl(ctl_ab), .din(din_ab), .flush(flush_ab),
        .clr_flags(clr_ab), .dout(a_dout), .count(a_count), .empty(a_empty),
        .full(a_full), .ovf(a_ovf), .unf(a_unf)
    );

    ret_addr_stack #(.AW(11), .DEPTH(8), .WRAP(0)) u_b (
        .clk(clk), .rst(rst), .ctl(ctl_ab), .din(din_ab), .flush(flush_ab),
        .clr_flags(clr_ab), .dout(b_dout), .count(b_count), .empty(b_empty),
        .full(b_full), .ovf(b_ovf), .unf(b_unf)
    );

    ret_addr_stack #(.AW(13), .DEPTH(5), .WRAP(1)) u_c (
        .clk(clk), .rst(rst), .ctl(ctl_c), .din(din_c), .flush(flush_c),
        .clr_flags(clr_c), .dout(c_dout), .count(c_count), .empty(c_empty),
        .full(c_full), .ovf(c_ovf), .unf(c_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_ab(input logic [1:0] op, input logic [10:0] d);
        ctl_ab = op;
        din_ab = d;
        tick();
        ctl_ab = STK_NOP;
    endtask

    task automatic op_c(input logic [1:0] op, input logic [12:0] d);
        ctl_c = op;
        din_c = d;
        tick();
        ctl_c = STK_NOP;
    endtask

    initial begin
        rst = 1'b1;
        ctl_ab = STK_NOP; din_ab = 11'h000; flush_ab = 1'b0; clr_ab = 1'b0;
        ctl_c  = STK_NOP; din_c  = 13'h0000; flush_c = 1'b0; clr_c  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and idle
        tick();
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_full",  32'(a_full),  32'd0);
        chk("rst_dout",  32'(a_dout),  32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_unf",   32'(a_unf),   32'd0);
        chk("rst_c_cnt", 32'(c_count), 32'd0);

        // Pop on empty
        op_ab(STK_POP, 11'h000);
        chk("pop_empty_unf", 32'(a_unf),   32'd1);
        chk("pop_empty_cnt", 32'(a_count), 32'd0);
        clr_ab = 1'b1; tick(); clr_ab = 1'b0;
        chk("clr_unf", 32'(a_unf), 32'd0);

        // Push 1..9 into circular (a) and saturating (b)
        for (int i = 1; i <= 9; i++) op_ab(STK_PSH, 11'(i));
        chk("wrap_count", 32'(a_count), 32'd8);
        chk("wrap_full",  32'(a_full),  32'd1);
        chk("wrap_ovf",   32'(a_ovf),   32'd1);
        chk("wrap_dout",  32'(a_dout),  32'h009);
        chk("sat_count",  32'(b_count), 32'd8);
        chk("sat_dout",   32'(b_dout),  32'h008);
        chk("sat_ovf",    32'(b_ovf),   32'd1);
        for (int k = 1; k <= 8; k++) begin
            op_ab(STK_POP, 11'h000);
            chk("wrap_pop", 32'(a_dout), (k == 8) ? 32'd0 : 32'(9 - k));
            chk("sat_pop",  32'(b_dout), (k == 8) ? 32'd0 : 32'(8 - k));
        end
        chk("wrap_empty", 32'(a_empty), 32'd1);
        chk("sat_empty",  32'(b_empty), 32'd1);
        chk("pops_no_unf", 32'(a_unf), 32'd0);

        // Replace top, then replace on empty
        clr_ab = 1'b1; tick(); clr_ab = 1'b0;
        op_ab(STK_PSH, 11'h123);
        op_ab(STK_RPL, 11'h456);
        chk("rpl_count", 32'(a_count), 32'd1);
        chk("rpl_dout",  32'(a_dout),  32'h456);
        op_ab(STK_POP, 11'h000);
        op_ab(STK_RPL, 11'h7FF);
        chk("rpl_e_count", 32'(a_count), 32'd1);
        chk("rpl_e_dout",  32'(a_dout),  32'h7FF);
        chk("rpl_e_unf",   32'(a_unf),   32'd1);

        // Flush beats a same-cycle push
        clr_ab = 1'b1; tick(); clr_ab = 1'b0;
        for (int i = 0; i < 3; i++) op_ab(STK_PSH, 11'(16 + i));
        chk("pre_flush_cnt", 32'(a_count), 32'd4);
        flush_ab = 1'b1;
        op_ab(STK_PSH, 11'h555);
        flush_ab = 1'b0;
        chk("flush_count", 32'(a_count), 32'd0);
        chk("flush_dout",  32'(a_dout),  32'd0);
        chk("flush_empty", 32'(a_empty), 32'd1);
        chk("flush_ovf",   32'(a_ovf),   32'd0);

        // Flag set wins over same-cycle clear
        for (int i = 0; i < 8; i++) op_ab(STK_PSH, 11'(32 + i));
        chk("refill_full", 32'(a_full), 32'd1);
        clr_ab = 1'b1;
        op_ab(STK_PSH, 11'h0AA);
        clr_ab = 1'b0;
        chk("set_wins_ovf", 32'(a_ovf), 32'd1);
        chk("set_wins_dout", 32'(a_dout), 32'h0AA);
        clr_ab = 1'b1; tick(); clr_ab = 1'b0;
        chk("clr_ovf", 32'(a_ovf), 32'd0);

        // Non-power-of-two depth with wrap
        for (int i = 1; i <= 7; i++) op_c(STK_PSH, 13'(32'h1000 + i));
        chk("c_count", 32'(c_count), 32'd5);
        chk("c_full",  32'(c_full),  32'd1);
        chk("c_ovf",   32'(c_ovf),   32'd1);
        chk("c_dout",  32'(c_dout),  32'h1007);
        for (int k = 1; k <= 5; k++) begin
            op_c(STK_POP, 13'h0000);
            chk("c_pop", 32'(c_dout), (k == 5) ? 32'd0 : 32'(32'h1007 - k));
        end
        chk("c_empty", 32'(c_empty), 32'd1);
        op_c(STK_PSH, 13'h0AAA);
        op_c(STK_PSH, 13'h1BBB);
        chk("c_pre_rst_cnt",  32'(c_count), 32'd2);
        chk("c_pre_rst_dout", 32'(c_dout),  32'h1BBB);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("async_c_count", 32'(c_count), 32'd0);
        chk("async_c_dout",  32'(c_dout),  32'd0);
        chk("async_c_empty", 32'(c_empty), 32'd1);
        chk("async_c_ovf",   32'(c_ovf),   32'd0);
        chk("async_a_count", 32'(a_count), 32'd0);
        chk("async_a_full",  32'(a_full),  32'd0);
        #2 rst = 1'b0;
        op_c(STK_PSH, 13'h0042);
        chk("post_rst_count", 32'(c_count), 32'd1);
        chk("post_rst_dout",  32'(c_dout),  32'h0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ret_addr_stack
